// File: rtl/axis_wrapper_top.sv
// AXI4-Stream datapoint reducer: popcounts NUM_PACKETS-beat datapoints and emits
// one {index, popcount} word per datapoint through a 4-deep fall-through FIFO.
module axis_wrapper_top #(
  parameter int C_S00_AXIS_DATA_WIDTH = 64,
  parameter int C_M00_AXIS_DATA_WIDTH = 64,
  parameter int NUM_PACKETS           = 13,
  parameter int DATAPOINTS            = 10
) (
  input  logic                                 s00_axis_aclk,
  input  logic                                 s00_axis_aresetn,
  output logic                                 s00_axis_tready,
  input  logic [C_S00_AXIS_DATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S00_AXIS_DATA_WIDTH/8)-1:0] s00_axis_tstrb,
  input  logic                                 s00_axis_tlast,
  input  logic                                 s00_axis_tvalid,
  input  logic                                 m00_axis_aclk,
  input  logic                                 m00_axis_aresetn,
  input  logic                                 m00_axis_tready,
  output logic [C_M00_AXIS_DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic                                 m00_axis_tlast,
  output logic                                 m00_axis_tvalid
);

  localparam int BEAT_W    = $clog2(NUM_PACKETS) + 1;
  localparam int IDX_W_MIN = $clog2(DATAPOINTS) + 1;
  localparam int IDX_W     = (IDX_W_MIN < 16) ? 16 : IDX_W_MIN;
  localparam int WORD_W    = C_M00_AXIS_DATA_WIDTH;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) cnt = cnt + {6'd0, v[i]};
    return cnt;
  endfunction

  logic              rst;
  logic              unused_ok;
  logic              s_ready_q, s_ready_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]       acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W:0]   mem_q [4];
  logic [WORD_W:0]   mem_d [4];
  logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]        count_q, count_d;
  logic              accept, close_dp, push, pop;
  logic [15:0]       acc_total;
  logic [WORD_W:0]   head;

  assign rst       = !s00_axis_aresetn;
  // The master-side clock/reset are tied to the slave ones; tstrb carries no meaning here.
  assign unused_ok = ^{s00_axis_tstrb, m00_axis_aclk, m00_axis_aresetn};

  assign accept    = s00_axis_tvalid && s_ready_q;
  assign acc_total = acc_q + {9'd0, popcount64(s00_axis_tdata[63:0])};
  assign close_dp  = accept && (s00_axis_tlast || (beat_cnt_q == BEAT_W'(NUM_PACKETS - 1)));
  assign push      = close_dp;
  assign pop       = (count_q != 3'd0) && m00_axis_tready;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (accept) begin
      if (close_dp) begin
        beat_cnt_d = '0;
        acc_d      = '0;
        idx_d      = s00_axis_tlast ? '0 : idx_q + IDX_W'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        acc_d      = acc_total;
      end
    end
    if (push) begin
      mem_d[wr_ptr_q] = {s00_axis_tlast, idx_q[15:0], 32'h0, acc_total};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    count_d   = count_q + {2'd0, push} - {2'd0, pop};
    // Ready is registered from the post-update occupancy so a full FIFO blocks the next beat.
    s_ready_d = (count_d < 3'd4);
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (rst) begin
      s_ready_q  <= 1'b0;
      beat_cnt_q <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      s_ready_q  <= s_ready_d;
      beat_cnt_q <= beat_cnt_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign s00_axis_tready = s_ready_q;
  assign m00_axis_tvalid = (count_q != 3'd0);
  assign m00_axis_tdata  = m00_axis_tvalid ? head[WORD_W-1:0] : '0;
  assign m00_axis_tlast  = m00_axis_tvalid && head[WORD_W];

endmodule

// File: tb/tb_axis_wrapper_top.sv
// Directed bench for axis_wrapper_top: reset, full frames, bubbles, backpressure,
// short frames and back-to-back frames, checked against hand-computed words.
module tb_axis_wrapper_top;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        s_tready;
  logic [63:0] s_tdata;
  logic [7:0]  s_tstrb;
  logic        s_tlast;
  logic        s_tvalid;
  logic        m_tready;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;

  int          total = 0;
  int          fails = 0;
  int          beat  = 0;
  bit          s_acc;
  logic [64:0] rx [$];

  always #5 clk = ~clk;

  axis_wrapper_top #(
    .C_S00_AXIS_DATA_WIDTH(64),
    .C_M00_AXIS_DATA_WIDTH(64),
    .NUM_PACKETS(13),
    .DATAPOINTS(10)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(aresetn),
    .s00_axis_tready (s_tready),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tvalid (s_tvalid),
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(aresetn),
    .m00_axis_tready (m_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tvalid (m_tvalid)
  );

  function automatic logic [64:0] word(input bit last, input int idx, input int cnt);
    return {last, 16'(idx), 32'h0, 16'(cnt)};
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample both handshakes mid-cycle, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (m_tvalid && m_tready) rx.push_back({m_tlast, m_tdata});
    s_acc = s_tvalid && s_tready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int flen, input int stop_at, input logic [63:0] data,
                       input int gap_at, input int gap_len, input int budget);
    int gap_left = 0;
    bit gap_done = 0;
    for (int c = 0; c < budget && beat < stop_at; c++) begin
      if (!gap_done && gap_at >= 0 && beat == gap_at) begin
        gap_left = gap_len;
        gap_done = 1;
      end
      if (gap_left > 0) begin
        s_tvalid = 1'b0;
        gap_left--;
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = data;
        s_tlast  = ((beat % flen) == flen - 1);
      end
      tick();
      if (s_acc) beat++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input int n, input int budget);
    for (int c = 0; c < budget && rx.size() < n; c++) tick();
  endtask

  task automatic check_frames(input string tag, input int nframes, input int cnt);
    int n;
    n = nframes * 10;
    check({tag, "_count"}, 65'(rx.size()), 65'(n));
    for (int i = 0; i < n && i < rx.size(); i++)
      check($sformatf("%s_res%0d", tag, i), rx[i], word((i % 10) == 9, i % 10, cnt));
  endtask

  initial begin
    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tstrb  = 8'hFF;
    s_tlast  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;

    // Reset
    tick();
    tick();
    check("rst_outputs", {62'd0, s_tready, m_tvalid, m_tlast}, 65'd0);
    check("rst_tdata", {1'b0, m_tdata}, 65'd0);
    aresetn = 1'b1;
    tick();
    check("ready_after_rst", {64'd0, s_tready}, 65'd1);

    // Full frame
    rx.delete(); beat = 0;
    drive(130, 130, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 400);
    drain(10, 50);
    check_frames("full", 1, 832);

    // Frame with a 13-cycle bubble after beat 36
    rx.delete(); beat = 0;
    drive(130, 130, 64'hFFFF_FFFF_FFFF_FFFF, 37, 13, 400);
    drain(10, 50);
    check_frames("bubble", 1, 832);

    // Master backpressure for the whole frame
    rx.delete(); beat = 0;
    m_tready = 1'b0;
    drive(130, 130, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 100);
    check("bp_beats_taken", 65'(beat), 65'd52);
    check("bp_s_tready", {64'd0, s_tready}, 65'd0);
    check("bp_head_held", {m_tvalid, m_tdata}, {1'b1, 16'd0, 32'h0, 16'd832});
    check("bp_rx_empty", 65'(rx.size()), 65'd0);
    m_tready = 1'b1;
    drive(130, 130, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 400);
    drain(10, 50);
    check_frames("bp", 1, 832);

    // Short frame: tlast on beat 5, one result one cycle after the closing beat
    rx.delete(); beat = 0;
    drive(6, 6, 64'h1, -1, 0, 50);
    check("short_latency", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b1, 16'd0, 32'h0, 16'd6});
    drain(1, 20);
    beat = 0;
    drive(2, 2, 64'h0000_0000_0000_00FF, -1, 0, 50);
    drain(2, 20);
    check("short_count", 65'(rx.size()), 65'd2);
    if (rx.size() >= 2) begin
      check("short_res0", rx[0], word(1, 0, 6));
      check("short_next_frame", rx[1], word(1, 0, 16));
    end

    // Back-to-back frames
    rx.delete(); beat = 0;
    drive(130, 260, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 800);
    drain(20, 50);
    check_frames("b2b", 2, 832);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
